// File: rtl/circ_stagger_interleave.sv
// circ_stagger_interleave
// Encoder-side CIRC stagger delay: word i of each accepted frame is delayed
// by i*STEP accepted frames (plus one register stage). The delay history is
// a circular frame buffer addressed by a write pointer; each word reads its
// own offset modulo the buffer depth.
//
// Optional feature: define CIRC_STAGGER_FLUSH_EN to add a FLUSH input that
// pushes all-zero frames through the buffer to drain the tail of a stream.
module circ_stagger_interleave #(
    parameter int WIDTH = 8,
    parameter int WORDS = 28,
    parameter int STEP  = 4
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   IN_VALID,
`ifdef CIRC_STAGGER_FLUSH_EN
    input  logic                   FLUSH,
`endif
    input  logic [WORDS*WIDTH-1:0] D,
    output logic                   OUT_VALID,
    output logic [WORDS*WIDTH-1:0] Q,
    output logic                   FILLED
);

    localparam int MAX_DELAY = (WORDS - 1) * STEP;
    localparam int DEPTH     = MAX_DELAY + 1;
    localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [WORDS*WIDTH-1:0] frame_t;

    frame_t           mem [DEPTH];
    logic [PTR_W-1:0] wp;
    logic [PTR_W-1:0] cnt;
    logic             accept;
    frame_t           din;
    frame_t           q_next;
    int               rd;
    logic [PTR_W-1:0] rd_addr;

    // Decide whether this cycle advances the buffer, and with which frame.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path can leave it unassigned and infer a latch.
        accept = IN_VALID;
        din    = D;
`ifdef CIRC_STAGGER_FLUSH_EN
        if (!IN_VALID && FLUSH) begin
            accept = 1'b1;
            din    = '0;
        end
`endif
    end

    // Gather each word from its delayed slot; history older than reset reads 0.
    always_comb begin
        q_next  = '0;
        rd      = 0;
        rd_addr = '0;
        // Word 0 has no frame delay; its slot is the one being written now.
        q_next[0 +: WIDTH] = din[0 +: WIDTH];
        for (int i = 1; i < WORDS; i++) begin
            // The counter saturates at MAX_DELAY, so it also says which
            // slots hold frames written since reset.
            if (int'(cnt) >= i * STEP) begin
                rd = int'(wp) - i * STEP;
                if (rd < 0) begin
                    rd = rd + DEPTH;
                end
                rd_addr = PTR_W'(rd);
                q_next[i*WIDTH +: WIDTH] = mem[rd_addr][i*WIDTH +: WIDTH];
            end
        end
    end

    // Frame buffer write port.
    // NOTE: the buffer has no reset; stale contents are masked by the frame
    // counter above, so clearing the storage is unnecessary.
    always_ff @(posedge CLK) begin
        if (accept) begin
            mem[wp] <= din;
        end
    end

    // Pointer, fill counter and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wp        <= '0;
            cnt       <= '0;
            OUT_VALID <= 1'b0;
            Q         <= '0;
            FILLED    <= 1'b0;
        end else begin
            OUT_VALID <= accept;
            if (accept) begin
                Q  <= q_next;
                wp <= (wp == PTR_W'(DEPTH - 1)) ? '0 : wp + 1'b1;
                if (cnt == PTR_W'(MAX_DELAY)) begin
                    FILLED <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_circ_stagger_interleave.sv
// Self-checking bench for circ_stagger_interleave: a reference model keyed by
// absolute frame number checks every output frame, and a table of
// hand-computed word values checks the captured outputs afterwards.
module tb_circ_stagger_interleave;

    localparam int W   = 8;
    localparam int WN  = 28;
    localparam int ST  = 4;
    localparam int MAXD = (WN - 1) * ST;

    typedef logic [WN*W-1:0] frame_t;

    typedef struct {
        int         scen;
        int         frame;
        int         word;
        logic [7:0] exp;
    } vec_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   in_valid = 1'b0;
    frame_t d_in = '0;
    logic   out_valid;
    frame_t q;
    logic   filled;
`ifdef CIRC_STAGGER_FLUSH_EN
    logic   flush = 1'b0;
`endif

    int     checks = 0;
    int     failures = 0;
    int     n_model = 0;
    frame_t last_q = '0;
    frame_t hist [0:511];

    frame_t cap1 [0:50];
    frame_t cap3 [0:109];
    logic   capf3 [0:109];
    frame_t cap4 [0:299];
    frame_t cap5;
    frame_t cap6 [0:127];

    circ_stagger_interleave #(.WIDTH(W), .WORDS(WN), .STEP(ST)) dut (
        .CLK      (clk),
        .RST_N    (rst_n),
        .IN_VALID (in_valid),
`ifdef CIRC_STAGGER_FLUSH_EN
        .FLUSH    (flush),
`endif
        .D        (d_in),
        .OUT_VALID(out_valid),
        .Q        (q),
        .FILLED   (filled)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input frame_t act, input frame_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic frame_t make_frame(input int n, input bit xor_idx);
        frame_t f;
        f = '0;
        for (int i = 0; i < WN; i++) begin
            f[i*W +: W] = n[7:0] ^ (xor_idx ? 8'(i) : 8'h00);
        end
        return f;
    endfunction

    function automatic frame_t model_q(input int n);
        frame_t f;
        f = '0;
        for (int i = 0; i < WN; i++) begin
            if (n - i * ST >= 0) begin
                f[i*W +: W] = hist[n - i*ST][i*W +: W];
            end
        end
        return f;
    endfunction

    // Compare one produced frame against the model and advance it.
    task automatic score(input frame_t d, output frame_t got, output logic got_f);
        hist[n_model] = d;
        check($sformatf("out_valid f%0d", n_model), frame_t'(out_valid), frame_t'(1'b1));
        check($sformatf("q f%0d", n_model), q, model_q(n_model));
        check($sformatf("filled f%0d", n_model), frame_t'(filled),
              frame_t'(n_model >= MAXD));
        got     = q;
        got_f   = filled;
        last_q  = q;
        n_model = n_model + 1;
    endtask

    task automatic send(input frame_t d, output frame_t got, output logic got_f);
        @(negedge clk);
        in_valid = 1'b1;
        d_in     = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        score(d, got, got_f);
    endtask

`ifdef CIRC_STAGGER_FLUSH_EN
    task automatic send_flush(output frame_t got, output logic got_f);
        @(negedge clk);
        flush = 1'b1;
        d_in  = '1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        score('0, got, got_f);
    endtask
`endif

    task automatic idle(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            check("gap out_valid", frame_t'(out_valid), '0);
            check("gap q hold", q, last_q);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("rst q", q, '0);
        check("rst out_valid", frame_t'(out_valid), '0);
        check("rst filled", frame_t'(filled), '0);
        @(negedge clk);
        rst_n   = 1'b1;
        n_model = 0;
        last_q  = '0;
    endtask

    function automatic logic [7:0] cap_word(input int scen, input int frame, input int word);
        frame_t f;
        case (scen)
            1:       f = cap1[frame];
            3:       f = cap3[frame];
            4:       f = cap4[frame];
            5:       f = cap5;
            default: f = cap6[frame];
        endcase
        return f[word*W +: W];
    endfunction

    initial begin
        vec_t   vecs[$];
        frame_t got;
        logic   gf;

        // Hand-computed expected words of selected output frames.
        vecs.push_back('{1, 50, 0, 8'h32});
        vecs.push_back('{1, 50, 1, 8'h2E});
        vecs.push_back('{1, 50, 2, 8'h2A});
        vecs.push_back('{1, 50, 12, 8'h02});
        vecs.push_back('{1, 50, 13, 8'h00});
        vecs.push_back('{1, 50, 27, 8'h00});
        vecs.push_back('{3, 107, 26, 8'h03});
        vecs.push_back('{3, 108, 0, 8'h6C});
        vecs.push_back('{3, 108, 26, 8'h04});
        vecs.push_back('{3, 108, 27, 8'h00});
        vecs.push_back('{4, 299, 0, 8'h2B});
        vecs.push_back('{4, 299, 1, 8'h26});
        vecs.push_back('{4, 299, 5, 8'h12});
        vecs.push_back('{4, 299, 27, 8'hA4});
        vecs.push_back('{5, 0, 0, 8'hAA});
        vecs.push_back('{5, 0, 1, 8'h00});
        vecs.push_back('{5, 0, 27, 8'h00});
`ifdef CIRC_STAGGER_FLUSH_EN
        vecs.push_back('{6, 127, 27, 8'h14});
        vecs.push_back('{6, 127, 26, 8'h00});
        vecs.push_back('{6, 127, 0, 8'h00});
`endif

        repeat (3) @(posedge clk);
        #1;
        check("init q", q, '0);
        check("init out_valid", frame_t'(out_valid), '0);
        check("init filled", frame_t'(filled), '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Scenario 1: back-to-back frames, every word of frame n = n.
        for (int n = 0; n <= 50; n++) begin
            send(make_frame(n, 1'b0), got, gf);
            cap1[n] = got;
        end

        // Scenario 2: same data with random idle gaps; outputs must match.
        do_reset();
        for (int n = 0; n <= 50; n++) begin
            idle(int'($urandom_range(0, 5)));
            send(make_frame(n, 1'b0), got, gf);
            check($sformatf("gap vs b2b f%0d", n), got, cap1[n]);
        end

        // Scenario 3: FILLED rises with the output of frame 108 and stays.
        do_reset();
        for (int n = 0; n <= 109; n++) begin
            send(make_frame(n, 1'b0), got, gf);
            cap3[n]  = got;
            capf3[n] = gf;
        end
        idle(2);
        check("filled f107", frame_t'(capf3[107]), '0);
        check("filled f108", frame_t'(capf3[108]), frame_t'(1'b1));
        check("filled sticky", frame_t'(filled), frame_t'(1'b1));

        // Scenario 4: nearly three pointer wraps, word i = n[7:0] ^ i.
        do_reset();
        for (int n = 0; n < 300; n++) begin
            send(make_frame(n, 1'b1), got, gf);
            cap4[n] = got;
        end

        // Scenario 5: asynchronous reset in the middle of frame 60.
        do_reset();
        for (int n = 0; n < 60; n++) begin
            send(make_frame(n, 1'b0), got, gf);
        end
        @(negedge clk);
        in_valid = 1'b1;
        d_in     = make_frame(60, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("async rst q", q, '0);
        check("async rst out_valid", frame_t'(out_valid), '0);
        check("async rst filled", frame_t'(filled), '0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        n_model = 0;
        last_q  = '0;
        send(make_frame(8'hAA, 1'b0), got, gf);
        cap5 = got;
        check("post rst filled", frame_t'(gf), '0);

`ifdef CIRC_STAGGER_FLUSH_EN
        // Scenario 6: 20 data frames (value n+1), then drain with 108 flushes.
        do_reset();
        for (int n = 0; n < 20; n++) begin
            send(make_frame(n + 1, 1'b0), got, gf);
            cap6[n] = got;
        end
        for (int n = 20; n < 128; n++) begin
            send_flush(got, gf);
            cap6[n] = got;
        end
`endif

        foreach (vecs[k]) begin
            check($sformatf("vec s%0d f%0d w%0d", vecs[k].scen, vecs[k].frame, vecs[k].word),
                  frame_t'(cap_word(vecs[k].scen, vecs[k].frame, vecs[k].word)),
                  frame_t'(vecs[k].exp));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
